// File: rtl/rally_referee_if.sv
// Referee <-> ball link: ball reports position/direction/hit count, referee sends hit and serve pulses.
interface rally_referee_if;
  logic [1:0]  direction;
  logic [15:0] light;
  logic [2:0]  hitnum;
  logic        leftdirection;
  logic        rightdirection;
  logic [1:0]  serve;

  modport master (
    input  direction, light, hitnum,
    output leftdirection, rightdirection, serve
  );

  modport slave (
    output direction, light, hitnum,
    input  leftdirection, rightdirection, serve
  );
endinterface

// File: rtl/rally_referee.sv
// Game controller for the ball block: forwards button presses as hit pulses, detects misses,
// keeps score, issues serves and declares a winner at WIN_SCORE.
module rally_referee #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_DELAY  = 8,
  parameter int unsigned MISS_CONFIRM = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  new_game,
  rally_referee_if.master       ball,
  output logic [3:0]            score_left,
  output logic [3:0]            score_right,
  output logic                  game_over,
  output logic [1:0]            winner,
  output logic [2:0]            max_rally
);

  localparam logic [1:0] SERVE_WAIT = 2'd0;
  localparam logic [1:0] RALLY      = 2'd1;
  localparam logic [1:0] POINT      = 2'd2;
  localparam logic [1:0] GAME_OVER  = 2'd3;

  localparam logic SRV_RIGHT = 1'b0;
  localparam logic SRV_LEFT  = 1'b1;

  localparam int unsigned DW = $clog2(MISS_CONFIRM + 1);
  localparam int unsigned CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  logic [1:0]    state_q, state_d;
  logic          server_q, server_d;
  logic          btn_left_prev_q, btn_right_prev_q;
  logic          leftdirection_q, leftdirection_d;
  logic          rightdirection_q, rightdirection_d;
  logic [1:0]    serve_q, serve_d;
  logic [3:0]    score_left_q, score_left_d;
  logic [3:0]    score_right_q, score_right_d;
  logic [1:0]    winner_q, winner_d;
  logic [2:0]    max_rally_q, max_rally_d;
  logic [DW-1:0] dark_cnt_q, dark_cnt_d;
  logic [CW-1:0] delay_cnt_q, delay_cnt_d;
  logic [1:0]    dir_prev_q;

  logic press_left, press_right;
  logic [3:0] scorer_score;

  assign press_left   = btn_left  & ~btn_left_prev_q;
  assign press_right  = btn_right & ~btn_right_prev_q;
  assign scorer_score = (server_q == SRV_LEFT) ? score_left_q : score_right_q;

  always_comb begin
    state_d          = state_q;
    server_d         = server_q;
    leftdirection_d  = 1'b0;
    rightdirection_d = 1'b0;
    serve_d          = 2'b00;
    score_left_d     = score_left_q;
    score_right_d    = score_right_q;
    winner_d         = winner_q;
    max_rally_d      = max_rally_q;
    dark_cnt_d       = '0;
    delay_cnt_d      = '0;

    case (state_q)
      SERVE_WAIT: begin
        if (server_q == SRV_RIGHT && press_right && ball.light == 16'h0001) begin
          leftdirection_d = 1'b1;
          state_d         = RALLY;
        end else if (server_q == SRV_LEFT && press_left && ball.light == 16'h8000) begin
          rightdirection_d = 1'b1;
          state_d          = RALLY;
        end
      end
      RALLY: begin
        rightdirection_d = press_left;
        leftdirection_d  = press_right;
        if (ball.hitnum > max_rally_q) max_rally_d = ball.hitnum;
        // A single dark cycle after a return flips direction, so it never accumulates.
        if (ball.light == '0 && ball.direction != 2'b00 && ball.direction == dir_prev_q)
          dark_cnt_d = dark_cnt_q + DW'(1);
        if (dark_cnt_d == DW'(MISS_CONFIRM)) begin
          dark_cnt_d = '0;
          state_d    = POINT;
          if (ball.direction == 2'b01) begin
            server_d      = SRV_RIGHT;
            score_right_d = (score_right_q == 4'hF) ? score_right_q : score_right_q + 4'd1;
          end else begin
            server_d     = SRV_LEFT;
            score_left_d = (score_left_q == 4'hF) ? score_left_q : score_left_q + 4'd1;
          end
        end
      end
      POINT: begin
        delay_cnt_d = delay_cnt_q + CW'(1);
        if (delay_cnt_q == CW'(SERVE_DELAY - 1)) begin
          delay_cnt_d = '0;
          if (scorer_score == 4'(WIN_SCORE)) begin
            state_d  = GAME_OVER;
            winner_d = (server_q == SRV_LEFT) ? 2'b10 : 2'b01;
          end else begin
            serve_d = (server_q == SRV_LEFT) ? 2'b10 : 2'b01;
            state_d = SERVE_WAIT;
          end
        end
      end
      GAME_OVER: begin
        if (new_game) begin
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = '0;
          max_rally_d   = '0;
          server_d      = SRV_RIGHT;
          serve_d       = 2'b01;
          state_d       = SERVE_WAIT;
        end
      end
      default: state_d = SERVE_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= SERVE_WAIT;
      server_q         <= SRV_RIGHT;
      btn_left_prev_q  <= 1'b0;
      btn_right_prev_q <= 1'b0;
      leftdirection_q  <= 1'b0;
      rightdirection_q <= 1'b0;
      serve_q          <= 2'b00;
      score_left_q     <= '0;
      score_right_q    <= '0;
      winner_q         <= '0;
      max_rally_q      <= '0;
      dark_cnt_q       <= '0;
      delay_cnt_q      <= '0;
      dir_prev_q       <= 2'b00;
    end else begin
      state_q          <= state_d;
      server_q         <= server_d;
      btn_left_prev_q  <= btn_left;
      btn_right_prev_q <= btn_right;
      leftdirection_q  <= leftdirection_d;
      rightdirection_q <= rightdirection_d;
      serve_q          <= serve_d;
      score_left_q     <= score_left_d;
      score_right_q    <= score_right_d;
      winner_q         <= winner_d;
      max_rally_q      <= max_rally_d;
      dark_cnt_q       <= dark_cnt_d;
      delay_cnt_q      <= delay_cnt_d;
      dir_prev_q       <= ball.direction;
    end
  end

  assign ball.leftdirection  = leftdirection_q;
  assign ball.rightdirection = rightdirection_q;
  assign ball.serve          = serve_q;
  assign score_left          = score_left_q;
  assign score_right         = score_right_q;
  assign game_over           = (state_q == GAME_OVER);
  assign winner              = winner_q;
  assign max_rally           = max_rally_q;

endmodule
